// File: rtl/gray_updn_nbits.sv
// Up/down Gray-code counter with synchronous load, terminal count and wrap/saturate modes.
// Optional shadow-counter consistency check is enabled by defining GRAY_ERR_CHK_EN.
module gray_updn_nbits #(
  parameter int unsigned N    = 4,
  parameter int unsigned WRAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         tc
`ifdef GRAY_ERR_CHK_EN
  ,
  output logic         err
`endif
);

  localparam logic [N-1:0] GRAY_MAX = {1'b1, {(N-1){1'b0}}};

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = '0;
    b[N-1] = g[N-1];
    for (int unsigned k = 1; k < N; k++) begin
      b[N-1-k] = b[N-k] ^ g[N-1-k];
    end
    return b;
  endfunction

  function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [N-1:0] gray_q;
  logic [N-1:0] bin_cur;
  logic [N-1:0] bin_step;
  logic [N-1:0] gray_step;
  logic         step_ok;

  always_comb begin
    bin_cur   = gray2bin(gray_q);
    tc        = up ? (gray_q == GRAY_MAX) : (gray_q == '0);
    // Saturating mode suppresses the step only at the end for the current direction.
    step_ok   = clk_en && ((WRAP != 0) || !tc);
    bin_step  = up ? (bin_cur + 1'b1) : (bin_cur - 1'b1);
    gray_step = bin2gray(bin_step);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gray_q <= '0;
    end else if (load) begin
      gray_q <= load_val;
    end else if (step_ok) begin
      gray_q <= gray_step;
    end
  end

  assign gray_out = gray_q;
  assign bin_out  = bin_cur;

`ifdef GRAY_ERR_CHK_EN
  logic [N-1:0] shadow_q;
  logic         shadow_tc;
  logic         shadow_ok;
  logic         err_q;

  always_comb begin
    shadow_tc = up ? (shadow_q == '1) : (shadow_q == '0);
    shadow_ok = clk_en && ((WRAP != 0) || !shadow_tc);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (load) begin
        shadow_q <= gray2bin(load_val);
      end else if (shadow_ok) begin
        shadow_q <= up ? (shadow_q + 1'b1) : (shadow_q - 1'b1);
      end
      if (bin_cur != shadow_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_gray_updn_nbits.sv
// Self-checking bench for gray_updn_nbits (N=4): WRAP=1 and WRAP=0 instances checked against
// an integer-count reference model with directed steps followed by randomized traffic.
module tb_gray_updn_nbits;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] gray_w, bin_w, gray_s, bin_s;
  logic       tc_w, tc_s;
`ifdef GRAY_ERR_CHK_EN
  logic       err_w, err_s;
`endif

  int checks = 0;
  int errors = 0;
  int unsigned mw = 0;
  int unsigned ms = 0;

  always #5 clk = ~clk;

  gray_updn_nbits #(.N(4), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .clk_en(clk_en), .up(up), .load(load), .load_val(load_val),
    .gray_out(gray_w), .bin_out(bin_w), .tc(tc_w)
`ifdef GRAY_ERR_CHK_EN
    , .err(err_w)
`endif
  );

  gray_updn_nbits #(.N(4), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .clk_en(clk_en), .up(up), .load(load), .load_val(load_val),
    .gray_out(gray_s), .bin_out(bin_s), .tc(tc_s)
`ifdef GRAY_ERR_CHK_EN
    , .err(err_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Position of a Gray code in the sequence, found by walking the sequence.
  function automatic int unsigned seq_index(input logic [3:0] g);
    for (int unsigned i = 0; i < 16; i++) begin
      if (4'((i ^ (i >> 1))) == g) return i;
    end
    return 0;
  endfunction

  function automatic int unsigned model_next(input int unsigned b, input bit wrap, input bit r,
                                             input bit e, input bit u, input bit l,
                                             input logic [3:0] lv);
    if (!r) return 0;
    if (l) return seq_index(lv);
    if (!e) return b;
    if (u) return (!wrap && b == 15) ? b : (b + 1) % 16;
    return (!wrap && b == 0) ? b : (b + 15) % 16;
  endfunction

  task automatic compare_all();
    check("gray_w", 32'(gray_w), mw ^ (mw >> 1));
    check("bin_w", 32'(bin_w), mw);
    check("tc_w", 32'(tc_w), 32'(up ? (mw == 15) : (mw == 0)));
    check("gray_s", 32'(gray_s), ms ^ (ms >> 1));
    check("bin_s", 32'(bin_s), ms);
    check("tc_s", 32'(tc_s), 32'(up ? (ms == 15) : (ms == 0)));
  endtask

  task automatic step(input bit r, input bit e, input bit u, input bit l, input logic [3:0] lv);
    logic [3:0] prev_w;
    @(negedge clk);
    rst = r; clk_en = e; up = u; load = l; load_val = lv;
    prev_w = gray_w;
    @(posedge clk);
    mw = model_next(mw, 1'b1, r, e, u, l, lv);
    ms = model_next(ms, 1'b0, r, e, u, l, lv);
    #1;
    compare_all();
    if (r && !l && e) check("one_bit_w", 32'($countones(prev_w ^ gray_w)), 32'd1);
  endtask

  logic [3:0] up_seq [17];
  logic [3:0] g_hold;

  initial begin
    up_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
               4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
               4'b0000};

    // Reset, then a full upward lap against the literal sequence.
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("reset_gray", 32'(gray_w), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      check("upseq", 32'(gray_w), 32'(up_seq[i]));
      check("upseq_tc", 32'(tc_w), 32'(up_seq[i] == 4'b1000));
    end

    // Downward wrap from zero.
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    check("tc_down_zero", 32'(tc_w), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    check("down_wrap_gray", 32'(gray_w), 32'h8);
    check("down_wrap_bin", 32'(bin_w), 32'hF);

    // Saturation at the top, then back off downward.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      check("sat_gray", 32'(gray_s), 32'h8);
      check("sat_tc", 32'(tc_s), 32'd1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    check("sat_release", 32'(gray_s), 32'h9);

    // Load wins over count on the same edge.
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110);
    check("load_gray", 32'(gray_w), 32'h6);
    check("load_bin", 32'(bin_w), 32'h4);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    check("load_then_up", 32'(gray_w), 32'h7);

    // Reset wins over load; then hold.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b1101);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101);
    check("rst_over_load", 32'(gray_w), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    check("hold_zero", 32'(gray_w), 32'd0);

    // A reset pulse between edges must not disturb the count.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b1011);
    @(negedge clk);
    g_hold = gray_w;
    rst = 1'b0;
    #2;
    check("no_async_rst", 32'(gray_w), 32'(g_hold));
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 9) == 0), 4'($urandom));
    end

`ifdef GRAY_ERR_CHK_EN
    // Corrupt the Gray register behind the shadow counter's back.
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    check("err_clear", 32'(err_w), 32'd0);
    @(negedge clk);
    clk_en = 1'b0;
    force dut_w.gray_q = 4'b0101;
    @(posedge clk);
    #1;
    check("err_set", 32'(err_w), 32'd1);
    release dut_w.gray_q;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("err_sticky", 32'(err_w), 32'd1);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("err_reset", 32'(err_w), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
